// File: rtl/cache_arb_fsm.sv
// Round-robin arbiter for cache-port misses. Each granted miss does an optional AXI write-back and
// then a line fill. The optional watchdog is enabled by defining CACHE_ARB_FSM_TIMEOUT_EN.
module cache_arb_fsm #(
   parameter int unsigned NUM_PORTS = 2,
   parameter int unsigned TIMEOUT_W = 8,
   localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                 i_clk,
   input  logic                 i_arst,
   input  logic [NUM_PORTS-1:0] i_req,
   input  logic [NUM_PORTS-1:0] i_hit,
   input  logic [NUM_PORTS-1:0] i_dirty,
   input  logic                 i_axi_done,
   output logic                 o_stall,
   output logic [NUM_PORTS-1:0] o_we,
   output logic                 o_axi_write_start,
   output logic                 o_axi_read_start,
   output logic [PW-1:0]        o_port_sel,
   output logic                 o_timeout
);

   localparam int unsigned IW = PW + 1;

   typedef enum logic [1:0] {
      StIdle,
      StWriteBack,
      StAllocate
   } state_e;

   state_e               state_q;
   logic [PW-1:0]        grant_q;
   logic [PW-1:0]        rr_ptr_q;
   logic [PW-1:0]        grant_idle;
   logic [PW-1:0]        rr_next;
   logic [NUM_PORTS-1:0] miss;
   logic                 miss_any;
   logic                 found;
   logic [IW-1:0]        idx;
   logic                 expire;

   assign miss     = i_req & ~i_hit;
   assign miss_any = |miss;
   assign rr_next  = (grant_q == PW'(NUM_PORTS - 1)) ? '0 : grant_q + PW'(1);

   // First missing port at or above rr_ptr, wrapping around.
   always_comb begin
      grant_idle = '0;
      found      = 1'b0;
      idx        = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         idx = {1'b0, rr_ptr_q} + IW'(i);
         if (idx >= IW'(NUM_PORTS)) begin
            idx = idx - IW'(NUM_PORTS);
         end
         if (!found && miss[idx]) begin
            found      = 1'b1;
            grant_idle = idx[PW-1:0];
         end
      end
   end

`ifdef CACHE_ARB_FSM_TIMEOUT_EN
   localparam logic [TIMEOUT_W-1:0] WdogLast = TIMEOUT_W'((1 << TIMEOUT_W) - 2);

   logic [TIMEOUT_W-1:0] wdog_q;

   // Held at zero in IDLE and on each done so every transfer phase starts a fresh count.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         wdog_q <= '0;
      end else if (state_q == StIdle || i_axi_done) begin
         wdog_q <= '0;
      end else begin
         wdog_q <= wdog_q + TIMEOUT_W'(1);
      end
   end

   assign expire = (state_q != StIdle) && !i_axi_done && (wdog_q == WdogLast);
`else
   logic [TIMEOUT_W-1:0] unused_wdog;

   assign unused_wdog = '0;
   assign expire      = 1'b0;
`endif

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state_q  <= StIdle;
         grant_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (miss_any) begin
                  grant_q <= grant_idle;
                  state_q <= i_dirty[grant_idle] ? StWriteBack : StAllocate;
               end
            end
            StWriteBack: begin
               if (i_axi_done) begin
                  state_q <= StAllocate;
               end else if (expire) begin
                  state_q  <= StIdle;
                  rr_ptr_q <= rr_next;
               end
            end
            StAllocate: begin
               if (i_axi_done || expire) begin
                  state_q  <= StIdle;
                  rr_ptr_q <= rr_next;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      o_stall           = 1'b0;
      o_we              = '0;
      o_axi_write_start = 1'b0;
      o_axi_read_start  = 1'b0;
      o_port_sel        = '0;
      o_timeout         = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (miss_any) begin
               o_stall    = 1'b1;
               o_port_sel = grant_idle;
               if (i_dirty[grant_idle]) begin
                  o_axi_write_start = 1'b1;
               end else begin
                  o_axi_read_start = 1'b1;
               end
            end
         end
         StWriteBack: begin
            o_stall           = 1'b1;
            o_port_sel        = grant_q;
            o_axi_write_start = ~i_axi_done;
            o_timeout         = expire;
         end
         StAllocate: begin
            o_stall          = 1'b1;
            o_port_sel       = grant_q;
            o_axi_read_start = ~i_axi_done;
            o_timeout        = expire;
            if (i_axi_done) begin
               o_we[grant_q] = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cache_arb_fsm.sv
// Bench for cache_arb_fsm (3 ports, 4-bit watchdog): directed vector table, reset/timeout
// sequences, then random traffic against a queue-based model of the pending AXI phases.
module tb_cache_arb_fsm;

`ifdef CACHE_ARB_FSM_TIMEOUT_EN
   localparam bit ToEn = 1'b1;
`else
   localparam bit ToEn = 1'b0;
`endif
   localparam int ToLimit = 15;  // cycles without done in one phase before expiry

   logic       i_clk = 1'b0;
   logic       i_arst;
   logic [2:0] i_req, i_hit, i_dirty;
   logic       i_axi_done;
   logic       o_stall, o_axi_write_start, o_axi_read_start, o_timeout;
   logic [2:0] o_we;
   logic [1:0] o_port_sel;

   cache_arb_fsm #(
      .NUM_PORTS(3),
      .TIMEOUT_W(4)
   ) dut (
      .i_clk            (i_clk),
      .i_arst           (i_arst),
      .i_req            (i_req),
      .i_hit            (i_hit),
      .i_dirty          (i_dirty),
      .i_axi_done       (i_axi_done),
      .o_stall          (o_stall),
      .o_we             (o_we),
      .o_axi_write_start(o_axi_write_start),
      .o_axi_read_start (o_axi_read_start),
      .o_port_sel       (o_port_sel),
      .o_timeout        (o_timeout)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_errors = 0;

   // Model: queue of AXI phases still owed by the current owner (1 = write-back, 2 = fill).
   int q[$];
   int m_port = 0;
   int m_rr = 0;
   int m_elapsed = 0;

   typedef struct {
      logic [2:0] req, hit, dirty;
      logic       done;
      logic       stall;
      logic [2:0] we;
      logic       ws, rs;
      logic [1:0] sel;
      int         reps;
      string      name;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [2:0] req, hit, dirty, input logic done, input logic stall,
                      input logic [2:0] we, input logic ws, rs, input logic [1:0] sel,
                      input int reps, input string name);
      vec_t v;
      v.req = req; v.hit = hit; v.dirty = dirty; v.done = done; v.stall = stall;
      v.we = we; v.ws = ws; v.rs = rs; v.sel = sel; v.reps = reps; v.name = name;
      tbl.push_back(v);
   endtask

   function automatic logic [8:0] outs();
      return {o_stall, o_we, o_axi_write_start, o_axi_read_start, o_port_sel, o_timeout};
   endfunction

   task automatic chk(input string name, input logic [8:0] got, input logic [8:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got {stall,we,ws,rs,sel,to}=%b want %b at %0t", name, got, want,
                  $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_rr = 0;
      m_elapsed = 0;
   endtask

   // One clock: drive inputs, compare at the falling edge, advance the model past the rising edge.
   task automatic step(input logic [2:0] req, hit, dirty, input logic done, input bit use_exp,
                       input logic e_stall, input logic [2:0] e_we, input logic e_ws, e_rs,
                       input logic [1:0] e_sel, input logic e_to, input string name);
      logic [2:0] m;
      logic [8:0] mdl;
      logic       to;
      int         p;
      bit         fnd;
      i_req = req; i_hit = hit; i_dirty = dirty; i_axi_done = done;
      m   = req & ~hit;
      mdl = '0;
      to  = 1'b0;
      p   = m_port;
      fnd = 1'b0;
      if (q.size() == 0) begin
         for (int k = 0; k < 3; k++) begin
            if (!fnd && m[(m_rr + k) % 3]) begin
               fnd = 1'b1;
               p   = (m_rr + k) % 3;
            end
         end
         if (fnd) mdl = {1'b1, 3'b000, dirty[p], ~dirty[p], 2'(p), 1'b0};
      end else begin
         to  = ToEn && !done && (m_elapsed == ToLimit - 1);
         mdl = {1'b1, (q[0] == 2 && done) ? 3'(1 << p) : 3'b000,
                q[0] == 1 && !done, q[0] == 2 && !done, 2'(p), to};
      end
      @(negedge i_clk);
      chk(name, outs(), use_exp ? {e_stall, e_we, e_ws, e_rs, e_sel, e_to} : mdl);
      n_checks++;
      if ((o_axi_write_start && o_axi_read_start) || !$onehot0(o_we)) begin
         n_errors++;
         $display("FAIL %s_exclusive: ws=%b rs=%b we=%b", name, o_axi_write_start,
                  o_axi_read_start, o_we);
      end
      @(posedge i_clk);
      if (q.size() == 0) begin
         if (fnd) begin
            m_port = p;
            m_elapsed = 0;
            if (dirty[p]) q = {1, 2};
            else q = {2};
         end
      end else if (done) begin
         void'(q.pop_front());
         m_elapsed = 0;
         if (q.size() == 0) m_rr = (m_port + 1) % 3;
      end else if (to) begin
         q.delete();
         m_rr = (m_port + 1) % 3;
      end else begin
         m_elapsed++;
      end
      #1;
   endtask

   initial begin
      logic [2:0] rq, rh, rd;
      logic       rdn;
      int         quiet;
      i_arst = 1'b1; i_req = '0; i_hit = '0; i_dirty = '0; i_axi_done = 1'b0;
      model_reset();
      repeat (2) @(posedge i_clk);
      #1;
      chk("reset_outputs", outs(), 9'b0);
      i_arst = 1'b0;

      //  req     hit     dirty   dn  stall we      ws rs sel    reps name
      add(3'b111, 3'b111, 3'b000, 0, 0, 3'b000, 0, 0, 2'd0, 10, "all_hit");
      add(3'b001, 3'b000, 3'b000, 0, 1, 3'b000, 0, 1, 2'd0, 1, "clean_idle_p0");
      add(3'b000, 3'b000, 3'b000, 0, 1, 3'b000, 0, 1, 2'd0, 2, "alloc_wait_p0");
      add(3'b000, 3'b000, 3'b000, 1, 1, 3'b001, 0, 0, 2'd0, 1, "alloc_done_p0");
      add(3'b100, 3'b000, 3'b100, 0, 1, 3'b000, 1, 0, 2'd2, 1, "dirty_idle_p2");
      add(3'b011, 3'b000, 3'b000, 0, 1, 3'b000, 1, 0, 2'd2, 1, "wb_wait_p2");
      add(3'b011, 3'b000, 3'b000, 1, 1, 3'b000, 0, 0, 2'd2, 1, "wb_done_p2");
      add(3'b000, 3'b000, 3'b000, 0, 1, 3'b000, 0, 1, 2'd2, 1, "alloc_after_wb");
      add(3'b000, 3'b000, 3'b000, 1, 1, 3'b100, 0, 0, 2'd2, 1, "alloc_done_p2");
      add(3'b111, 3'b000, 3'b000, 0, 1, 3'b000, 0, 1, 2'd0, 1, "rr_grant0");
      add(3'b111, 3'b000, 3'b111, 1, 1, 3'b001, 0, 0, 2'd0, 1, "rr_done0");
      add(3'b111, 3'b000, 3'b000, 0, 1, 3'b000, 0, 1, 2'd1, 2, "rr_grant1");
      add(3'b111, 3'b000, 3'b000, 1, 1, 3'b010, 0, 0, 2'd1, 1, "rr_done1");
      add(3'b111, 3'b000, 3'b000, 0, 1, 3'b000, 0, 1, 2'd2, 1, "rr_grant2");
      add(3'b111, 3'b000, 3'b000, 1, 1, 3'b100, 0, 0, 2'd2, 1, "rr_done2");
      add(3'b111, 3'b000, 3'b000, 0, 1, 3'b000, 0, 1, 2'd0, 1, "rr_wrap0");
      add(3'b000, 3'b000, 3'b000, 1, 1, 3'b001, 0, 0, 2'd0, 1, "rr_wrap0_done");
      add(3'b001, 3'b000, 3'b000, 0, 1, 3'b000, 0, 1, 2'd0, 1, "search_wraps");
      add(3'b000, 3'b000, 3'b000, 1, 1, 3'b001, 0, 0, 2'd0, 1, "search_wraps_done");
      add(3'b011, 3'b010, 3'b010, 0, 1, 3'b000, 0, 1, 2'd0, 1, "dirty_of_hit_ignored");
      add(3'b000, 3'b000, 3'b000, 1, 1, 3'b001, 0, 0, 2'd0, 1, "dirty_of_hit_done");
      add(3'b000, 3'b000, 3'b000, 1, 0, 3'b000, 0, 0, 2'd0, 1, "done_in_idle");
      foreach (tbl[i]) begin
         for (int r = 0; r < tbl[i].reps; r++) begin
            step(tbl[i].req, tbl[i].hit, tbl[i].dirty, tbl[i].done, 1'b1, tbl[i].stall,
                 tbl[i].we, tbl[i].ws, tbl[i].rs, tbl[i].sel, 1'b0, tbl[i].name);
         end
      end

      // Reset two cycles into a fill for port 1: transfer dropped, pointer back to port 0.
      step(3'b010, 3'b000, 3'b000, 0, 1'b1, 1, 3'b000, 0, 1, 2'd1, 0, "pre_reset_grant1");
      step(3'b000, 3'b000, 3'b000, 0, 1'b1, 1, 3'b000, 0, 1, 2'd1, 0, "pre_reset_alloc");
      step(3'b000, 3'b000, 3'b000, 0, 1'b1, 1, 3'b000, 0, 1, 2'd1, 0, "pre_reset_alloc2");
      i_arst = 1'b1; i_req = 3'b111; i_hit = 3'b000; i_dirty = 3'b000; i_axi_done = 1'b1;
      #1;
      chk("reset_async_idle_view", outs(), {1'b1, 3'b000, 1'b0, 1'b1, 2'd0, 1'b0});
      @(posedge i_clk);
      #1;
      chk("reset_held_no_we", outs(), {1'b1, 3'b000, 1'b0, 1'b1, 2'd0, 1'b0});
      i_arst = 1'b0;
      model_reset();
      step(3'b111, 3'b000, 3'b000, 0, 1'b1, 1, 3'b000, 0, 1, 2'd0, 0, "post_reset_grant0");
      step(3'b000, 3'b000, 3'b000, 1, 1'b1, 1, 3'b001, 0, 0, 2'd0, 0, "post_reset_done0");

      // Long fill for port 1 with no done.
      step(3'b010, 3'b000, 3'b000, 0, 1'b1, 1, 3'b000, 0, 1, 2'd1, 0, "slow_grant1");
`ifdef CACHE_ARB_FSM_TIMEOUT_EN
      for (int k = 1; k < ToLimit; k++) begin
         step(3'b000, 3'b000, 3'b000, 0, 1'b1, 1, 3'b000, 0, 1, 2'd1, 0, "slow_wait");
      end
      step(3'b000, 3'b000, 3'b000, 0, 1'b1, 1, 3'b000, 0, 1, 2'd1, 1, "timeout_pulse");
      step(3'b000, 3'b000, 3'b000, 0, 1'b1, 0, 3'b000, 0, 0, 2'd0, 0, "timeout_idle");
      step(3'b101, 3'b000, 3'b000, 0, 1'b1, 1, 3'b000, 0, 1, 2'd2, 0, "after_timeout_p2");
      for (int k = 1; k < ToLimit; k++) begin
         step(3'b000, 3'b000, 3'b000, 0, 1'b1, 1, 3'b000, 0, 1, 2'd2, 0, "late_wait");
      end
      step(3'b000, 3'b000, 3'b000, 1, 1'b1, 1, 3'b100, 0, 0, 2'd2, 0, "done_beats_timeout");
`else
      for (int k = 1; k <= 20; k++) begin
         step(3'b000, 3'b000, 3'b000, 0, 1'b1, 1, 3'b000, 0, 1, 2'd1, 0, "no_watchdog_wait");
      end
      step(3'b000, 3'b000, 3'b000, 1, 1'b1, 1, 3'b010, 0, 0, 2'd1, 0, "no_watchdog_done");
`endif

      quiet = 0;
      for (int c = 0; c < 600; c++) begin
         rq = 3'($urandom); rh = 3'($urandom); rd = 3'($urandom);
         if (quiet > 0) begin
            quiet--;
            rdn = 1'b0;
         end else begin
            rdn = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 40) == 0) quiet = $urandom_range(10, 20);
         end
         step(rq, rh, rd, rdn, 1'b0, 0, 3'b000, 0, 0, 2'd0, 0, "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
